// File: rtl/serial_pkg.sv
// Shared types and frame constants for the UART word transmitter.
// Frame length depends on SERIAL_TX_PARITY_EN (even parity bit after data).
package serial_pkg;

   localparam int DATA_BITS = 8;

`ifdef SERIAL_TX_PARITY_EN
   localparam int FRAME_BITS = DATA_BITS + 3;
`else
   localparam int FRAME_BITS = DATA_BITS + 2;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_DONE
   } state_e;

   function automatic logic [7:0] byte_sel(
      input logic [31:0] w,
      input logic [1:0]  idx
   );
      return w[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and wraps.
// tick marks the last cycle of each serial bit.
module baud_counter
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/serial_tx_device.sv
// Word-to-UART responder: sends BYTES frames LSB-first, then pulses finish.
// Define SERIAL_TX_PARITY_EN to insert an even parity bit in every frame.
module serial_tx_device
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int BYTES        = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] data,
   output logic        finish,
   output logic        busy,
   output logic        tx
);

   localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

   state_e        state_q, state_d;
   logic [BW-1:0] byte_q, byte_d;
   logic [2:0]    bit_q, bit_d;
   logic [31:0]   word_q, word_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          fin_q, fin_d;

   logic tick;
   logic accept;
   logic baud_en;

   assign accept  = (state_q == S_IDLE) && start;
   assign baud_en = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_STOP);

   baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clock  (clock),
      .reset_n(reset_n),
      .enable (baud_en),
      .clear  (accept),
      .tick   (tick)
   );

`ifdef SERIAL_TX_PARITY_EN
   logic par;
   assign par = ^byte_sel(word_q, 2'(byte_q));
`endif

   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      bit_d   = bit_q;
      word_d  = word_q;
      shift_d = shift_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               word_d  = data;
               byte_d  = '0;
               bit_d   = '0;
               shift_d = data[7:0];
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (byte_q == LAST_BYTE) begin
                  state_d = S_DONE;
               end else begin
                  byte_d  = byte_q + 1'b1;
                  shift_d = byte_sel(word_q, 2'(byte_d));
                  state_d = S_START;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change with it.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state_d != S_IDLE);
      fin_d  = (state_d == S_DONE);
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: tx_d = par;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         byte_q  <= '0;
         bit_q   <= '0;
         word_q  <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         bit_q   <= bit_d;
         word_q  <= word_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         fin_q   <= fin_d;
      end
   end

   assign tx     = tx_q;
   assign busy   = busy_q;
   assign finish = fin_q;

endmodule

// File: tb/tb_serial_tx_device.sv
// Randomized checks of serial_tx_device against a per-cycle line model.
// Honors SERIAL_TX_PARITY_EN when the build defines it.
module tb_serial_tx_device;

   localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int FRAME = PAR ? 11 : 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start0 = 1'b0;
   logic        start1 = 1'b0;
   logic [31:0] data0 = '0;
   logic [31:0] data1 = '0;
   logic        fin0, busy0, tx0;
   logic        fin1, busy1, tx1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_tx_device #(.CLKS_PER_BIT(CPB), .BYTES(4)) u_dut4 (
      .clock  (clk),
      .reset_n(rst_n),
      .start  (start0),
      .data   (data0),
      .finish (fin0),
      .busy   (busy0),
      .tx     (tx0)
   );

   serial_tx_device #(.CLKS_PER_BIT(CPB), .BYTES(1)) u_dut1 (
      .clock  (clk),
      .reset_n(rst_n),
      .start  (start1),
      .data   (data1),
      .finish (fin1),
      .busy   (busy1),
      .tx     (tx1)
   );

   task automatic drive(input int sel, input logic s, input logic [31:0] d);
      if (sel == 0) begin
         start0 = s;
         data0  = d;
      end else begin
         start1 = s;
         data1  = d;
      end
   endtask

   function automatic logic [2:0] outs(input int sel);
      return (sel == 0) ? {tx0, busy0, fin0} : {tx1, busy1, fin1};
   endfunction

   // Expected line is built bit-by-bit from the frame format, then
   // compared cycle by cycle; inj != 0 pulses start with junk data then.
   task automatic check_word(input int sel, input logic [31:0] w,
                             input int nb, input int inj,
                             input logic [31:0] injw, input string name);
      logic q[$];
      logic [7:0] b;
      logic [2:0] o, e;
      int n;
      for (int i = 0; i < nb; i++) begin
         b = w[8*i +: 8];
         for (int r = 0; r < CPB; r++) q.push_back(1'b0);
         for (int k = 0; k < 8; k++)
            for (int r = 0; r < CPB; r++) q.push_back(b[k]);
         if (PAR)
            for (int r = 0; r < CPB; r++) q.push_back(^b);
         for (int r = 0; r < CPB; r++) q.push_back(1'b1);
      end
      n = q.size();
      drive(sel, 1'b1, w);
      for (int c = 1; c <= n + 2; c++) begin
         @(negedge clk);
         if (c == inj) drive(sel, 1'b1, injw);
         else drive(sel, 1'b0, w);
         o = outs(sel);
         if (c <= n) e = {q[c-1], 2'b10};
         else if (c == n + 1) e = 3'b111;
         else e = 3'b100;
         total++;
         if (o !== e) begin
            bad++;
            if (bad <= 20)
               $display("FAIL %s k+%0d tx/busy/finish got %b want %b",
                        name, c, o, e);
         end
      end
   endtask

   task automatic test_reset();
      logic [5:0] o;
      repeat (2) @(negedge clk);
      o = {outs(0), outs(1)};
      total++;
      if (o !== 6'b100100) begin
         bad++;
         $display("FAIL reset_hold got %b want %b", o, 6'b100100);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      o = {outs(0), outs(1)};
      total++;
      if (o !== 6'b100100) begin
         bad++;
         $display("FAIL reset_idle got %b want %b", o, 6'b100100);
      end
   endtask

   task automatic test_basic();
      check_word(0, 32'h4433_2211, 4, 0, '0, "basic");
   endtask

   task automatic test_ignore_busy();
      check_word(0, 32'h4433_2211, 4, 50, 32'hFFFF_FFFF, "ignore_busy");
   endtask

   task automatic test_done_window();
      int n;
      n = 4 * FRAME * CPB;
      check_word(0, $urandom, 4, n + 1, $urandom, "done_start");
      check_word(0, $urandom, 4, 0, '0, "back_to_back");
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++)
         check_word(0, $urandom, 4, $urandom_range(2, 150), $urandom,
                    "random");
   endtask

   task automatic test_single_byte();
      check_word(1, 32'h0000_00A5, 1, 0, '0, "one_byte_a5");
      check_word(1, 32'h0000_0007, 1, 20, $urandom, "one_byte_07");
      check_word(1, $urandom, 1, 0, '0, "one_byte_rand");
   endtask

   task automatic test_abort();
      logic [2:0] o;
      int hits;
      drive(0, 1'b1, $urandom);
      @(negedge clk);
      drive(0, 1'b0, '0);
      repeat (30) @(negedge clk);
      total++;
      if (busy0 !== 1'b1) begin
         bad++;
         $display("FAIL abort_busy_before got %b want 1", busy0);
      end
      rst_n = 1'b0;
      #1;
      o = outs(0);
      total++;
      if (o !== 3'b100) begin
         bad++;
         $display("FAIL abort_async got %b want %b", o, 3'b100);
      end
      @(negedge clk);
      rst_n = 1'b1;
      hits = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (outs(0) !== 3'b100) hits++;
      end
      total++;
      if (hits != 0) begin
         bad++;
         $display("FAIL abort_after got %0d non-idle cycles want 0", hits);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_busy();
      test_done_window();
      test_random();
      test_single_byte();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
